// File: rtl/div_seq_if.sv
// Handshake bundle for div_seq: operand channel (in_*, A, B) and result channel (out_*, Q, R, flags).
interface div_seq_if #(
  parameter int SIZE = 8
) ();
  logic                       in_valid;
  logic                       in_ready;
  logic signed [2*SIZE-1:0]   A;
  logic signed [SIZE-1:0]     B;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [2*SIZE-1:0]   Q;
  logic signed [SIZE-1:0]     R;
  logic                       div_zero;
  logic                       ovf;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Q, R, div_zero, ovf
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Q, R, div_zero, ovf
  );
endinterface

// File: rtl/div_seq.sv
// Sequential signed divider, 2*SIZE-bit dividend by SIZE-bit divisor, one quotient bit per cycle.
// Truncates toward zero; divide-by-zero and min/-1 saturate and bypass the iteration.
module div_seq #(
  parameter int SIZE = 8
) (
  input logic     clk,
  input logic     resetn,
  div_seq_if.slave bus
);
  localparam int W  = 2 * SIZE;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic                  sign_a, sign_b;
  logic [W-1:0]          dvd;
  logic [W-1:0]          quo;
  logic [SIZE:0]         mag_b;
  logic [SIZE:0]         rem;
  logic [CW-1:0]         cnt;
  logic signed [W-1:0]   q_reg;
  logic signed [SIZE-1:0] r_reg;
  logic                  dz_reg, ovf_reg;

  logic                  accept;
  logic                  b_zero, a_min_b_neg1;
  logic [W-1:0]          abs_a;
  logic [SIZE:0]         b_ext, abs_b;
  logic [SIZE:0]         trial, trial_diff;
  logic                  trial_ge;

  // Operand decode
  always_comb begin
    accept       = bus.in_valid && bus.in_ready;
    abs_a        = bus.A[W-1] ? (~bus.A + W'(1)) : bus.A;
    b_ext        = {bus.B[SIZE-1], bus.B};
    abs_b        = bus.B[SIZE-1] ? (~b_ext + (SIZE+1)'(1)) : b_ext;
    b_zero       = (bus.B == '0);
    a_min_b_neg1 = (bus.A == {1'b1, {(W-1){1'b0}}}) && (bus.B == '1);
  end

  // Restoring step; rem[SIZE] stands in for the bit shifted out of the low bits,
  // which forces the subtract and keeps the difference exact modulo 2^(SIZE+1).
  always_comb begin
    trial      = {rem[SIZE-1:0], dvd[W-1]};
    trial_ge   = rem[SIZE] || (trial >= mag_b);
    trial_diff = trial - mag_b;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = (b_zero || a_min_b_neg1) ? DONE : CALC;
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = resetn && (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.Q         = q_reg;
    bus.R         = r_reg;
    bus.div_zero  = dz_reg;
    bus.ovf       = ovf_reg;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      dvd     <= '0;
      quo     <= '0;
      mag_b   <= '0;
      rem     <= '0;
      cnt     <= '0;
      q_reg   <= '0;
      r_reg   <= '0;
      dz_reg  <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sign_a <= bus.A[W-1];
            sign_b <= bus.B[SIZE-1];
            dvd    <= abs_a;
            mag_b  <= abs_b;
            rem    <= '0;
            quo    <= '0;
            cnt    <= CW'(W - 1);
            if (b_zero) begin
              q_reg  <= bus.A[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
              r_reg  <= '0;
              dz_reg <= 1'b1;
            end else if (a_min_b_neg1) begin
              q_reg   <= {1'b0, {(W-1){1'b1}}};
              r_reg   <= '0;
              ovf_reg <= 1'b1;
            end
          end
        end
        CALC: begin
          rem <= trial_ge ? trial_diff : trial;
          quo <= {quo[W-2:0], trial_ge};
          dvd <= {dvd[W-2:0], 1'b0};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          q_reg <= (sign_a ^ sign_b) ? (~quo + W'(1)) : quo;
          r_reg <= sign_a ? (~rem[SIZE-1:0] + SIZE'(1)) : rem[SIZE-1:0];
        end
        DONE: begin
          if (bus.out_ready) begin
            dz_reg  <= 1'b0;
            ovf_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed vector table, backpressure and reset corner cases, randomized run vs model.
module tb_div_seq;
  localparam int SIZE  = 8;
  localparam int W     = 2 * SIZE;
  localparam int QMAX  = 2 ** (W - 1) - 1;
  localparam int QMIN  = -(2 ** (W - 1));
  localparam int NRAND = 1000;

  logic clk = 1'b0;
  logic resetn;

  div_seq_if #(.SIZE(SIZE)) bus ();
  div_seq #(.SIZE(SIZE)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int a; int b; int q; int r; int dz; int ov; int lat;
  } vec_t;

  typedef struct {
    int a; int b; int q; int r; int dz; int ov;
  } res_t;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Truncating signed division with the saturation rules for /0 and min/-1.
  function automatic void model(input int a, input int b,
                                output int q, output int r, output int dz, output int ov);
    dz = 0; ov = 0;
    if (b == 0) begin
      q = (a >= 0) ? QMAX : QMIN; r = 0; dz = 1;
    end else if (a == QMIN && b == -1) begin
      q = QMAX; r = 0; ov = 1;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Called at the negedge after the accept edge; counts cycles from the accept cycle.
  task automatic wait_result(output int lat, output int rdy_seen);
    lat = 1;
    rdy_seen = int'(bus.in_ready);
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (bus.in_ready) rdy_seen = 1;
    end
  endtask

  task automatic run_op(input int a, input int b,
                        output int q, output int r, output int dz, output int ov,
                        output int lat, output int rdy_seen);
    int n;
    n = 0;
    @(negedge clk);
    bus.A = W'(a); bus.B = SIZE'(b); bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    #1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A = W'($urandom);
    bus.B = SIZE'($urandom);
    wait_result(lat, rdy_seen);
    q = int'(bus.Q); r = int'(bus.R); dz = int'(bus.div_zero); ov = int'(bus.ovf);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[14];
    res_t sb[$];
    res_t e;
    int q, r, dz, ov, lat, rs;
    int accepted, results, cyc, ca, cb, sel;
    bit pend;

    vecs[0]  = '{100, 7, 14, 2, 0, 0, 18};
    vecs[1]  = '{-100, 7, -14, -2, 0, 0, 18};
    vecs[2]  = '{100, -7, -14, 2, 0, 0, 18};
    vecs[3]  = '{-100, -7, 14, -2, 0, 0, 18};
    vecs[4]  = '{-32768, -128, 256, 0, 0, 0, 18};
    vecs[5]  = '{32767, -128, -255, 127, 0, 0, 18};
    vecs[6]  = '{1234, 0, 32767, 0, 1, 0, 1};
    vecs[7]  = '{-5, 0, -32768, 0, 1, 0, 1};
    vecs[8]  = '{-32768, -1, 32767, 0, 0, 1, 1};
    vecs[9]  = '{50, 3, 16, 2, 0, 0, 18};
    vecs[10] = '{-32768, 1, -32768, 0, 0, 0, 18};
    vecs[11] = '{0, 5, 0, 0, 0, 0, 18};
    vecs[12] = '{7, 100, 0, 7, 0, 0, 18};
    vecs[13] = '{-32767, 127, -258, -1, 0, 0, 18};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.A = '0; bus.B = '0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_Q", int'(bus.Q), 0);
    check("rst_R", int'(bus.R), 0);
    check("rst_div_zero", int'(bus.div_zero), 0);
    check("rst_ovf", int'(bus.ovf), 0);
    resetn = 1'b1;
    #1;
    check("post_rst_in_ready", int'(bus.in_ready), 1);

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].a, vecs[i].b, q, r, dz, ov, lat, rs);
      check($sformatf("vec%0d_Q", i), q, vecs[i].q);
      check($sformatf("vec%0d_R", i), r, vecs[i].r);
      check($sformatf("vec%0d_div_zero", i), dz, vecs[i].dz);
      check($sformatf("vec%0d_ovf", i), ov, vecs[i].ov);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_in_ready_busy", i), rs, 0);
      check($sformatf("vec%0d_out_valid_drop", i), int'(bus.out_valid), 0);
      check($sformatf("vec%0d_in_ready_after", i), int'(bus.in_ready), 1);
    end

    // Backpressure: result held, pending operand waits for the output handshake.
    @(negedge clk);
    bus.A = W'(1000); bus.B = SIZE'(-9); bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_result(lat, rs);
    check("bp_latency", lat, 18);
    bus.A = W'(-77); bus.B = SIZE'(4); bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_hold_Q", int'(bus.Q), -111);
      check("bp_hold_R", int'(bus.R), 1);
      check("bp_hold_flags", int'({bus.div_zero, bus.ovf}), 0);
      check("bp_hold_out_valid", int'(bus.out_valid), 1);
      check("bp_hold_in_ready", int'(bus.in_ready), 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_release_out_valid", int'(bus.out_valid), 0);
    check("bp_release_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_result(lat, rs);
    check("bp_pending_latency", lat, 18);
    check("bp_pending_Q", int'(bus.Q), -19);
    check("bp_pending_R", int'(bus.R), -1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Asynchronous reset in the middle of an iteration.
    bus.A = W'(100); bus.B = SIZE'(7); bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_Q", int'(bus.Q), 0);
    check("midrst_R", int'(bus.R), 0);
    check("midrst_in_ready", int'(bus.in_ready), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    check("midrst_release_in_ready", int'(bus.in_ready), 1);
    run_op(50, 3, q, r, dz, ov, lat, rs);
    check("midrst_next_Q", q, 16);
    check("midrst_next_R", r, 2);
    check("midrst_next_latency", lat, 18);

    // Randomized traffic with gaps on both channels.
    accepted = 0; results = 0; cyc = 0; pend = 1'b0; ca = 0; cb = 0;
    while (results < NRAND && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (!pend && accepted < NRAND && $urandom_range(3) != 0) begin
        ca  = int'($urandom_range(65535)) - 32768;
        sel = int'($urandom_range(15));
        if (sel == 0)      cb = 0;
        else if (sel == 1) begin ca = QMIN; cb = -1; end
        else if (sel == 2) cb = -128;
        else               cb = int'($urandom_range(255)) - 128;
        pend = 1'b1;
      end
      bus.in_valid  = pend;
      bus.A         = W'(ca);
      bus.B         = SIZE'(cb);
      bus.out_ready = ($urandom_range(1) == 1);
      #1;
      if (bus.in_ready && bus.out_valid) check("rand_ready_valid_exclusive", 1, 0);
      if (bus.in_valid && bus.in_ready) begin
        e.a = ca; e.b = cb;
        model(ca, cb, e.q, e.r, e.dz, e.ov);
        sb.push_back(e);
        accepted++;
        pend = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("rand_unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rand_Q", int'(bus.Q), e.q);
          check("rand_R", int'(bus.R), e.r);
          check("rand_div_zero", int'(bus.div_zero), e.dz);
          check("rand_ovf", int'(bus.ovf), e.ov);
          if (e.dz == 0 && e.ov == 0)
            check("rand_identity", int'(bus.Q) * e.b + int'(bus.R), e.a);
        end
        results++;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    check("rand_accept_count", accepted, NRAND);
    check("rand_result_count", results, NRAND);
    check("rand_scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
